// File: rtl/syn_run_ctl_if.sv
// Signal bundle between the board/core side and the run/step controller.
interface syn_run_ctl_if;
   logic        run_req;
   logic        step_req;
   logic        speed;
   logic        halt;
   logic [31:0] pc;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic        en;
   logic [1:0]  state;
   logic        bp_hit;
   logic [31:0] instr_cnt;

   // Board and core side: drives the requests, PC and breakpoint setup.
   modport master (
      output run_req, step_req, speed, halt, pc, bp_en, bp_addr,
      input  en, state, bp_hit, instr_cnt
   );

   // Controller side.
   modport slave (
      input  run_req, step_req, speed, halt, pc, bp_en, bp_addr,
      output en, state, bp_hit, instr_cnt
   );
endinterface

// File: rtl/syn_run_ctl.sv
// Run/step controller: generates the core enable for free-run, single-step,
// PC breakpoints and halt, and counts retired instructions.
module syn_run_ctl #(
   parameter logic [31:0] DIV_FAST = 32'd1,
   parameter logic [31:0] DIV_SLOW = 32'd50_000_000
) (
   input  logic          clk,
   input  logic          rst_n,
   syn_run_ctl_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        run_q, step_q;
   logic [31:0] div_cnt_q, div_cnt_d;
   logic        bp_hit_q, bp_hit_d;
   logic        bp_skip_q, bp_skip_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;

   logic        run_rise_s, step_rise_s, tick_s, bp_match_s, en_s;
   logic [31:0] period_s;

   // Request edges, rate divider compare and breakpoint match.
   always_comb begin
      run_rise_s  = bus.run_req & ~run_q;
      step_rise_s = bus.step_req & ~step_q;
      period_s    = bus.speed ? DIV_SLOW : DIV_FAST;
      // >= rather than == so a switch to a shorter period ticks at once.
      tick_s      = (div_cnt_q >= (period_s - 32'd1));
      bp_match_s  = bus.bp_en & (bus.pc == bus.bp_addr) & ~bp_skip_q;
   end

   // Core enable, next state and sticky flags.
   always_comb begin
      en_s = rst_n & ~bus.halt &
             (((state_q == ST_RUN) & tick_s & ~run_rise_s & ~bp_match_s) |
              (state_q == ST_STEP));

      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bp_hit_d    = bp_hit_q;
      // Any retired instruction re-arms the breakpoint.
      bp_skip_d   = en_s ? 1'b0 : bp_skip_q;
      instr_cnt_d = en_s ? (instr_cnt_q + 32'd1) : instr_cnt_q;

      if (bus.halt && (state_q != ST_HALT)) begin
         state_d = ST_HALT;
      end else begin
         case (state_q)
            ST_PAUSE: begin
               if (run_rise_s) begin
                  state_d   = ST_RUN;
                  bp_hit_d  = 1'b0;
                  // Resuming at the breakpoint PC must execute it.
                  bp_skip_d = 1'b1;
                  div_cnt_d = 32'd0;
               end else if (step_rise_s) begin
                  state_d = ST_STEP;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            ST_RUN: begin
               if (tick_s) begin
                  div_cnt_d = 32'd0;
               end else begin
                  div_cnt_d = div_cnt_q + 32'd1;
               end
               if (run_rise_s) begin
                  state_d = ST_PAUSE;
               end else if (bp_match_s) begin
                  state_d  = ST_PAUSE;
                  bp_hit_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_STEP: begin
               state_d = ST_PAUSE;
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_PAUSE;
            end
         endcase
      end
   end

   // State registers; edge detectors sample through reset so held inputs make no edge.
   always_ff @(posedge clk) begin
      run_q  <= bus.run_req;
      step_q <= bus.step_req;
      if (!rst_n) begin
         state_q     <= ST_PAUSE;
         div_cnt_q   <= 32'd0;
         bp_hit_q    <= 1'b0;
         bp_skip_q   <= 1'b0;
         instr_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bp_hit_q    <= bp_hit_d;
         bp_skip_q   <= bp_skip_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign bus.en        = en_s;
   assign bus.state     = state_q;
   assign bus.bp_hit    = bp_hit_q;
   assign bus.instr_cnt = instr_cnt_q;
endmodule
